// File: rtl/cmd_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : cmd_mem_loader
// Purpose  : Write-side loader for the banked command memory. Accepts a
//            valid/ready stream of MEM_WIDTH words and scatters them across
//            MEM_TO_CMD banks. Word i of each command goes to bank i, so
//            bank 0 holds the least-significant word of a CMD_WIDTH command.
// Ports    : clk, rstn        - clock, asynchronous active-low reset
//            start, abort     - load request (IDLE only) / cancel (LOAD only)
//            base_addr        - first command address, sampled on start
//            n_cmds           - command count 0..2^CMD_ADDR_WIDTH
//            in_data/valid    - input stream word / valid
//            in_ready         - loader accepts a word (LOAD state)
//            mem_wr_en        - one-hot bank write enable (registered)
//            mem_wr_addr/data - bank write address / data (registered)
//            busy             - high while loading
//            done             - one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module cmd_mem_loader #(
    parameter int CMD_ADDR_WIDTH = 8,
    parameter int MEM_WIDTH      = 32,
    parameter int MEM_TO_CMD     = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic                      abort,
    input  logic [CMD_ADDR_WIDTH-1:0] base_addr,
    input  logic [CMD_ADDR_WIDTH:0]   n_cmds,
    input  logic [MEM_WIDTH-1:0]      in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [MEM_TO_CMD-1:0]     mem_wr_en,
    output logic [CMD_ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [MEM_WIDTH-1:0]      mem_wr_data,
    output logic                      busy,
    output logic                      done
);

    // Bank counter width; kept at least 1 bit so a single-bank build still elaborates.
    localparam int c_bank_w = (MEM_TO_CMD > 1) ? $clog2(MEM_TO_CMD) : 1;

    localparam logic [c_bank_w-1:0]       c_last_bank = c_bank_w'(MEM_TO_CMD - 1);
    localparam logic [c_bank_w-1:0]       c_bank_inc  = c_bank_w'(1);
    localparam logic [MEM_TO_CMD-1:0]     c_bank_one  = MEM_TO_CMD'(1);
    localparam logic [CMD_ADDR_WIDTH-1:0] c_addr_inc  = CMD_ADDR_WIDTH'(1);
    localparam logic [CMD_ADDR_WIDTH:0]   c_rem_one   = (CMD_ADDR_WIDTH + 1)'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]                r_state;
    logic [1:0]                w_state_next;
    logic [CMD_ADDR_WIDTH-1:0] r_addr;
    logic [c_bank_w-1:0]       r_bank;
    logic [CMD_ADDR_WIDTH:0]   r_remaining;

    logic [MEM_TO_CMD-1:0]     r_wr_en;
    logic [CMD_ADDR_WIDTH-1:0] r_wr_addr;
    logic [MEM_WIDTH-1:0]      r_wr_data;

    logic w_in_ready;
    logic w_busy;
    logic w_done;
    logic w_start_load;
    logic w_accept;
    logic w_cmd_end;
    logic w_last_beat;

    // abort wins over a coincident beat: that word is dropped, not written.
    assign w_accept     = (r_state == c_st_load) && in_valid && !abort;
    assign w_cmd_end    = (r_bank == c_last_bank);
    assign w_last_beat  = w_accept && w_cmd_end && (r_remaining == c_rem_one);
    assign w_start_load = (r_state == c_st_idle) && start && (n_cmds != '0);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and state-decoded outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    // A zero-length load completes without touching memory.
                    w_state_next = (n_cmds == '0) ? c_st_done : c_st_load;
                end
            end
            c_st_load: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (abort) begin
                    w_state_next = c_st_idle;
                end else if (w_last_beat) begin
                    w_state_next = c_st_done;
                end
            end
            c_st_done: begin
                // Coincides with the registered final write.
                w_done       = 1'b1;
                w_state_next = c_st_idle;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Address / bank / remaining-command counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr      <= '0;
            r_bank      <= '0;
            r_remaining <= '0;
        end else if (w_start_load) begin
            r_addr      <= base_addr;
            r_bank      <= '0;
            r_remaining <= n_cmds;
        end else if (w_accept) begin
            if (w_cmd_end) begin
                r_bank      <= '0;
                r_addr      <= r_addr + c_addr_inc;   // wraps modulo depth
                r_remaining <= r_remaining - c_rem_one;
            end else begin
                r_bank <= r_bank + c_bank_inc;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered write port: one cycle after acceptance. Address and data
    // hold between writes; only the enable returns to zero.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_en   <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_accept ? (c_bank_one << r_bank) : '0;
            if (w_accept) begin
                r_wr_addr <= r_addr;
                r_wr_data <= in_data;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign busy        = w_busy;
    assign done        = w_done;
    assign mem_wr_en   = r_wr_en;
    assign mem_wr_addr = r_wr_addr;
    assign mem_wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_cmd_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_mem_loader
// Purpose  : Directed self-checking bench for cmd_mem_loader. A reference
//            model of address/bank/remaining pushes expected writes into a
//            scoreboard queue; a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_mem_loader;

    localparam int AW  = 8;
    localparam int MW  = 32;
    localparam int MTC = 4;

    logic          clk       = 1'b0;
    logic          rstn      = 1'b0;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   n_cmds    = '0;
    logic [MW-1:0] in_data   = '0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [MTC-1:0] mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [MW-1:0] mem_wr_data;
    logic          busy;
    logic          done;

    cmd_mem_loader #(
        .CMD_ADDR_WIDTH(AW),
        .MEM_WIDTH     (MW),
        .MEM_TO_CMD    (MTC)
    ) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .n_cmds     (n_cmds),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [MTC-1:0] en;
        logic [AW-1:0]  addr;
        logic [MW-1:0]  data;
        logic           dn;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    int n_cmp = 0;
    int n_err = 0;
    int busy_cnt = 0;
    bit lone_done_ok = 1'b0;

    // Reference model
    bit            m_loading = 1'b0;
    logic [AW-1:0] m_addr;
    int            m_bank;
    int            m_rem;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (busy === 1'b1) busy_cnt++;
            if (mem_wr_en !== '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(mem_wr_en), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_en",   64'(mem_wr_en),   64'(mon_e.en));
                    check("wr_addr", 64'(mem_wr_addr), 64'(mon_e.addr));
                    check("wr_data", 64'(mem_wr_data), 64'(mon_e.data));
                    check("wr_done", 64'(done),        64'(mon_e.dn));
                end
            end else if (done !== 1'b0 && !lone_done_ok) begin
                check("stray_done", 64'(done), 64'd0);
            end
        end
    end

    // Called just after a rising edge; returns just after the next one.
    task automatic start_load(input logic [AW-1:0] ba, input int n);
        start     = 1'b1;
        base_addr = ba;
        n_cmds    = (AW + 1)'(n);
        m_loading = (n != 0);
        m_addr    = ba;
        m_bank    = 0;
        m_rem     = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_word(input logic [MW-1:0] d, input bit v, input bit ab);
        wr_t e;
        in_data  = d;
        in_valid = v;
        abort    = ab;
        if (v && !ab && m_loading) begin
            e.en   = MTC'(1) << m_bank;
            e.addr = m_addr;
            e.data = d;
            e.dn   = (m_bank == MTC - 1) && (m_rem == 1);
            exp_q.push_back(e);
            if (m_bank == MTC - 1) begin
                m_bank = 0;
                m_addr = m_addr + 1'b1;
                m_rem--;
                if (m_rem == 0) m_loading = 1'b0;
            end else begin
                m_bank++;
            end
        end
        if (ab) m_loading = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        abort    = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en",   64'(mem_wr_en),   64'd0);
        check("rst_wr_addr", 64'(mem_wr_addr), 64'd0);
        check("rst_wr_data", 64'(mem_wr_data), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy",    64'(busy), 64'd0);
        check("rst_done",    64'(done), 64'd0);
        rstn = 1'b1;
        idle_cycles(2);

        // 1: two commands back-to-back
        busy_cnt = 0;
        start_load(8'h10, 2);
        check("t1_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 8; i++) drive_word(MW'(32'h11 + i), 1'b1, 1'b0);
        check("t1_done_state", 64'(done), 64'd1);
        idle_cycles(2);
        check("t1_busy_cycles", 64'(busy_cnt), 64'd8);
        check("t1_drained", 64'(exp_q.size()), 64'd0);

        // 2: same load with in_valid 1,0,0,1,0,0,...
        start_load(8'h10, 2);
        for (int i = 0; i < 8; i++) begin
            drive_word(MW'(32'h11 + i), 1'b1, 1'b0);
            if (i != 7) begin
                drive_word(32'hDEAD_0000, 1'b0, 1'b0);
                drive_word(32'hDEAD_0001, 1'b0, 1'b0);
            end
        end
        idle_cycles(2);
        check("t2_drained", 64'(exp_q.size()), 64'd0);

        // 3: address wrap at the top of memory
        start_load(8'hFF, 2);
        for (int i = 0; i < 8; i++) drive_word(MW'(32'hA0 + i), 1'b1, 1'b0);
        idle_cycles(2);
        check("t3_drained", 64'(exp_q.size()), 64'd0);

        // 4: zero-length load; words offered are not consumed
        lone_done_ok = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hBAD0_0004;
        start_load(8'h22, 0);
        check("t4_done_next", 64'(done), 64'd1);
        check("t4_in_ready",  64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("t4_done_gone", 64'(done), 64'd0);
        check("t4_in_ready_idle", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        lone_done_ok = 1'b0;
        idle_cycles(2);

        // 5: second start ignored, abort (with coincident beat) after word 3
        start_load(8'h40, 1);
        drive_word(32'h51, 1'b1, 1'b0);
        drive_word(32'h52, 1'b1, 1'b0);
        start     = 1'b1;
        base_addr = 8'h77;
        n_cmds    = 9'd3;
        @(posedge clk); #1;
        start = 1'b0;
        drive_word(32'h53, 1'b1, 1'b0);
        drive_word(32'h54, 1'b1, 1'b1);
        check("t5_in_ready_abort", 64'(in_ready), 64'd0);
        check("t5_busy_abort",     64'(busy), 64'd0);
        idle_cycles(2);
        check("t5_drained", 64'(exp_q.size()), 64'd0);
        start_load(8'h30, 1);
        for (int i = 0; i < 4; i++) drive_word(MW'(32'hC0 + i), 1'b1, 1'b0);
        idle_cycles(2);
        check("t5_reload_drained", 64'(exp_q.size()), 64'd0);

        // 6: asynchronous reset mid-load
        start_load(8'h20, 2);
        for (int i = 0; i < 5; i++) drive_word(MW'(32'hE0 + i), 1'b1, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        exp_q.delete();
        m_loading = 1'b0;
        check("t6_wr_en",   64'(mem_wr_en),   64'd0);
        check("t6_wr_addr", 64'(mem_wr_addr), 64'd0);
        check("t6_wr_data", 64'(mem_wr_data), 64'd0);
        check("t6_in_ready", 64'(in_ready), 64'd0);
        check("t6_busy",    64'(busy), 64'd0);
        idle_cycles(2);
        rstn = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hBAD0_0006;
        idle_cycles(2);
        check("t6_in_ready_post", 64'(in_ready), 64'd0);
        check("t6_busy_post",     64'(busy), 64'd0);
        in_valid = 1'b0;
        idle_cycles(2);
        check("t6_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
